hex_cmd_parser: RTL and testbench

//  Downstream consumer of the UART receiver in the hex calculator. Collects ASCII

---
 rtl/hex_cmd_parser.sv | 199 +++++++++++++++++++
 tb/tb_hex_cmd_parser.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_cmd_parser.sv
// Hex calculator command parser: collects "<A><op><B><term>" from the UART RX byte stream,
// computes the result and streams it back as uppercase ASCII hex plus CR LF to the UART TX.
module hex_cmd_parser #(
    parameter int OP_DIGITS  = 4,
    parameter int RES_DIGITS = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       busy,
    output logic       err
);
    localparam int OW = 4 * OP_DIGITS;
    localparam int RW = 4 * RES_DIGITS;
    localparam int CW = $clog2(OP_DIGITS + 1);
    localparam int IW = $clog2(RES_DIGITS + 2);
    localparam logic [CW-1:0] CNT_MAX  = CW'(OP_DIGITS);
    localparam logic [IW-1:0] LAST_RES = IW'(RES_DIGITS + 1);
    localparam logic [IW-1:0] LAST_ERR = IW'(2);

    typedef enum logic [2:0] {GET_A, GET_B, CALC, SEND, ERR} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

    function automatic logic is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
               (c >= 8'h61 && c <= 8'h66);
    endfunction

    // Letters of either case share the low nibble 1..6 for A..F.
    function automatic logic [3:0] hex_nib(input logic [7:0] c);
        if (c <= 8'h39) return c[3:0];
        return c[3:0] + 4'd9;
    endfunction

    function automatic logic [7:0] nib_ascii(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic is_op(input logic [7:0] c);
        return (c == 8'h2B) || (c == 8'h2D) || (c == 8'h2A);
    endfunction

    function automatic op_t op_code(input logic [7:0] c);
        case (c)
            8'h2D:   return OP_SUB;
            8'h2A:   return OP_MUL;
            default: return OP_ADD;
        endcase
    endfunction

    function automatic logic is_term(input logic [7:0] c);
        return (c == 8'h3D) || (c == 8'h0D);
    endfunction

    function automatic logic is_skip(input logic [7:0] c);
        return (c == 8'h20) || (c == 8'h0A);
    endfunction

    state_t          state_q;
    op_t             op_q;
    logic [OW-1:0]   a_q, b_q;
    logic [CW-1:0]   cnt_a_q, cnt_b_q;
    logic [RW-1:0]   r_q;
    logic [IW-1:0]   idx_q;
    logic            is_err_q, wait_q, rx_valid_q;
    logic [7:0]      tx_data_q;
    logic            tx_start_q, busy_q, err_q;

    logic            ev;
    logic [3:0]      nib;
    logic [RW-1:0]   a_ext, b_ext, res_d;
    logic [7:0]      send_byte_d;

    assign ev    = rx_valid & ~rx_valid_q;
    assign nib   = hex_nib(rx_data);
    assign a_ext = RW'(a_q);
    assign b_ext = RW'(b_q);

    always_comb begin
        case (op_q)
            OP_SUB:  res_d = a_ext - b_ext;
            OP_MUL:  res_d = a_ext * b_ext;
            default: res_d = a_ext + b_ext;
        endcase
    end

    // Byte at idx_q of the outgoing line: result digits MSB first, or "?", then CR LF.
    always_comb begin
        send_byte_d = 8'h0A;
        if (is_err_q) begin
            if (idx_q == '0)
                send_byte_d = 8'h3F;
            else if (idx_q == IW'(1))
                send_byte_d = 8'h0D;
        end else if (idx_q == IW'(RES_DIGITS)) begin
            send_byte_d = 8'h0D;
        end else begin
            for (int i = 0; i < RES_DIGITS; i++)
                if (idx_q == IW'(i))
                    send_byte_d = nib_ascii(r_q[4*(RES_DIGITS-1-i) +: 4]);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= GET_A;
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            r_q        <= '0;
            idx_q      <= '0;
            is_err_q   <= 1'b0;
            wait_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                GET_A: if (ev) begin
                    if (is_hex(rx_data)) begin
                        a_q <= OW'({a_q, nib});
                        if (cnt_a_q != CNT_MAX) cnt_a_q <= cnt_a_q + 1'b1;
                    end else if (is_op(rx_data) && cnt_a_q != '0) begin
                        op_q    <= op_code(rx_data);
                        state_q <= GET_B;
                    end else if (!is_skip(rx_data)) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                GET_B: if (ev) begin
                    if (is_hex(rx_data)) begin
                        b_q <= OW'({b_q, nib});
                        if (cnt_b_q != CNT_MAX) cnt_b_q <= cnt_b_q + 1'b1;
                    end else if (is_term(rx_data) && cnt_b_q != '0) begin
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                    end else if (!is_skip(rx_data)) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                CALC: begin
                    r_q      <= res_d;
                    idx_q    <= '0;
                    is_err_q <= 1'b0;
                    wait_q   <= 1'b0;
                    state_q  <= SEND;
                end
                ERR: begin
                    idx_q    <= '0;
                    is_err_q <= 1'b1;
                    wait_q   <= 1'b0;
                    state_q  <= SEND;
                end
                SEND: begin
                    // The cycle after a pulse is skipped: tx_busy is not yet valid for our byte.
                    if (wait_q) begin
                        wait_q <= 1'b0;
                    end else if (!tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= send_byte_d;
                        wait_q     <= 1'b1;
                        if (idx_q == (is_err_q ? LAST_ERR : LAST_RES)) begin
                            state_q <= GET_A;
                            busy_q  <= 1'b0;
                            a_q     <= '0;
                            b_q     <= '0;
                            cnt_a_q <= '0;
                            cnt_b_q <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= GET_A;
            endcase
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_hex_cmd_parser.sv
// Bench for hex_cmd_parser: byte-level RX driver, TX transmitter emulator and a
// string-based reference model of the calculator command language.
module tb_hex_cmd_parser;
    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    byte unsigned rxq[$];
    int   tx_hold    = 4;
    int   busy_cnt   = 0;
    int   proto_viol = 0;
    int   err_pulses = 0;
    int   err_hi     = 0;
    logic prev_start = 1'b0;
    logic prev_err   = 1'b0;

    hex_cmd_parser #(.OP_DIGITS(4), .RES_DIGITS(8)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // UART transmitter stand-in: captures bytes, holds tx_busy for tx_hold cycles.
    always @(negedge clk) begin
        if (!n_rst) begin
            tx_busy    = 1'b0;
            busy_cnt   = 0;
            prev_start = 1'b0;
            prev_err   = 1'b0;
        end else begin
            if (err === 1'b1) begin
                err_hi++;
                if (prev_err !== 1'b1) err_pulses++;
            end
            prev_err = err;
            if (tx_start === 1'b1) begin
                rxq.push_back(tx_data);
                if (prev_start === 1'b1 || tx_busy) proto_viol++;
            end
            prev_start = tx_start;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
            if (tx_start === 1'b1) begin
                busy_cnt = tx_hold;
                tx_busy  = 1'b1;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic int hexval(input byte unsigned c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 'h30;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 'h37;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 'h57;
        return -1;
    endfunction

    // Reference: returns the expected reply and how many bytes of cmd complete the command.
    function automatic string model(input string cmd, output int used);
        longint a = 0, b = 0;
        int na = 0, nb = 0, phase = 0, v;
        byte unsigned c, op = 8'h2B;
        logic [31:0] r;
        string h;
        used = cmd.len();
        for (int i = 0; i < cmd.len(); i++) begin
            c = cmd[i];
            v = hexval(c);
            used = i + 1;
            if (c == 8'h20 || c == 8'h0A) continue;
            if (v >= 0) begin
                if (phase == 0) begin a = (a * 16 + v) % 65536; na++; end
                else begin b = (b * 16 + v) % 65536; nb++; end
                continue;
            end
            if ((c == 8'h2B || c == 8'h2D || c == 8'h2A) && phase == 0 && na > 0) begin
                phase = 1;
                op = c;
                continue;
            end
            if ((c == 8'h3D || c == 8'h0D) && phase == 1 && nb > 0) begin
                if (op == 8'h2B) r = 32'(a + b);
                else if (op == 8'h2D) r = 32'(a - b);
                else r = 32'(a * b);
                h = $sformatf("%08h", r);
                return {h.toupper(), "\015\012"};
            end
            return "?\015\012";
        end
        return "";
    endfunction

    function automatic string hexdump(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02h ", s[i])};
        return r;
    endfunction

    function automatic string q2str();
        string r = "";
        foreach (rxq[i]) r = $sformatf("%s%c", r, rxq[i]);
        return r;
    endfunction

    function automatic byte unsigned hexchar();
        int v = $urandom_range(0, 15);
        if (v < 10) return 8'(8'h30 + v);
        return 8'(($urandom_range(0, 1) ? 8'h41 : 8'h61) + v - 10);
    endfunction

    function automatic string gen_cmd();
        string s = "";
        byte unsigned ops[3] = '{8'h2B, 8'h2D, 8'h2A};
        int kind = $urandom_range(0, 9);
        int na = (kind == 0) ? 0 : $urandom_range(1, 6);
        int nb = (kind == 1) ? 0 : $urandom_range(1, 6);
        for (int i = 0; i < na; i++) begin
            s = $sformatf("%s%c", s, hexchar());
            if ($urandom_range(0, 7) == 0) s = {s, " "};
        end
        s = $sformatf("%s%c", s, ops[$urandom_range(0, 2)]);
        for (int i = 0; i < nb; i++) begin
            s = $sformatf("%s%c", s, hexchar());
            if ($urandom_range(0, 7) == 0) s = {s, "\012"};
        end
        if (kind == 2) s = {s, "G"};
        if (kind == 3) s = {s, "*"};
        s = {s, ($urandom_range(0, 1) ? "=" : "\015")};
        return s;
    endfunction

    task automatic send_byte(input byte unsigned b, input int hold);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (hold) @(negedge clk);
        rx_valid = 1'b0;
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int hold);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], hold);
    endtask

    task automatic check_resp(input string exp, input string name);
        int budget = exp.len() * (tx_hold + 6) + 200;
        int cyc = 0;
        string got;
        while ((rxq.size() < exp.len() || busy || tx_busy) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d bytes, required %0d", name, rxq.size(), exp.len());
        end
        repeat (3) @(negedge clk);
        got = q2str();
        rxq.delete();
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: tx bytes [%s] required [%s]", name, hexdump(got), hexdump(exp));
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b required 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h required 00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err); end
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_basic();
        int e0 = err_pulses;
        tx_hold = 4;
        send_str("12+34\015", 3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_term: got %b required 1", busy); end
        check_resp("00000046\015\012", "add_12_34");
        send_str("ffff*FFFF=", 2);
        check_resp("FFFE0001\015\012", "mul_ffff");
        send_str("1-2\015", 2);
        check_resp("FFFFFFFF\015\012", "sub_wrap");
        send_str("12345+1=", 2);
        check_resp("00002346\015\012", "five_digits");
        send_str("FFFF+FFFF\015", 1);
        check_resp("0001FFFE\015\012", "add_carry");
        send_str("a b+ 1\0122=", 2);
        check_resp("000000BD\015\012", "skip_space_lf");
        checks++; if (err_pulses != e0) begin errors++; $display("FAIL basic_no_err: got %0d pulses required 0", err_pulses - e0); end
    endtask

    task automatic test_errors();
        int e0 = err_pulses;
        int h0 = err_hi;
        send_str("+", 3);
        check_resp("?\015\012", "err_leading_op");
        checks++; if (err_pulses - e0 != 1) begin errors++; $display("FAIL err_pulse_count: got %0d required 1", err_pulses - e0); end
        send_str("1G", 3);
        check_resp("?\015\012", "err_bad_char");
        send_str("5=", 2);
        check_resp("?\015\012", "err_term_in_a");
        send_str("7+\015", 2);
        check_resp("?\015\012", "err_empty_b");
        send_str("1+2+", 2);
        check_resp("?\015\012", "err_op_in_b");
        checks++; if (err_pulses - e0 != 5) begin errors++; $display("FAIL err_total: got %0d required 5", err_pulses - e0); end
        checks++; if (err_hi - h0 != 5) begin errors++; $display("FAIL err_width: got %0d high cycles required 5", err_hi - h0); end
        send_str("2+2\015", 2);
        check_resp("00000004\015\012", "err_recovery");
    endtask

    task automatic test_slow_rx();
        send_str("a+b\015", 435);
        check_resp("00000015\015\012", "slow_rx_level");
    endtask

    task automatic test_drop_while_busy();
        send_str("3+4\015", 2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy_flag: got %b required 1", busy); end
        send_str("9+", 2);
        check_resp("00000007\015\012", "drop_during_send");
        send_str("1+1\015", 2);
        check_resp("00000002\015\012", "after_drop");
    endtask

    task automatic test_slow_tx();
        int v0 = proto_viol;
        tx_hold = 500;
        send_str("12+34\015", 2);
        check_resp("00000046\015\012", "slow_tx");
        checks++; if (proto_viol != v0) begin errors++; $display("FAIL slow_tx_handshake: got %0d violations required 0", proto_viol - v0); end
        tx_hold = 4;
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        bit found = 0;
        tx_hold = 4;
        send_str("12+34\015", 2);
        while (rxq.size() < 3 && cyc < 2000) begin @(negedge clk); cyc++; end
        cyc = 0;
        while (!found && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (tx_start === 1'b1) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL mid_4th_pulse: got no tx_start required one"); end
        n_rst = 1'b0;
        #1;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL mid_reset_tx_start: got %b required 0", tx_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b required 0", busy); end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        rxq.delete();
        repeat (2) @(negedge clk);
        send_str("2+2\015", 2);
        check_resp("00000004\015\012", "after_mid_reset");
    endtask

    task automatic test_random();
        string cmd, exp;
        int used;
        for (int i = 0; i < 30; i++) begin
            tx_hold = $urandom_range(1, 6);
            cmd = gen_cmd();
            exp = model(cmd, used);
            send_str(cmd.substr(0, used - 1), $urandom_range(1, 4));
            check_resp(exp, $sformatf("rand_%0d", i));
        end
        tx_hold = 4;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_slow_rx();
        test_drop_while_busy();
        test_slow_tx();
        test_reset_mid();
        test_random();
        checks++;
        if (proto_viol != 0) begin
            errors++;
            $display("FAIL tx_handshake: got %0d violations required 0", proto_viol);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
